// File: rtl/gate_unit_pkg.sv
// gate_unit_pkg: mode codes and gate evaluation shared by the debounced gate unit
package gate_unit_pkg;
    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_XOR  = 3'd2;
    localparam logic [2:0] MODE_NAND = 3'd3;
    localparam logic [2:0] MODE_NOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;
    localparam logic [2:0] MODE_LAST = MODE_XNOR;

    function automatic logic gate_fn(input logic [2:0] m, input logic all1, input logic any1, input logic par);
        return m == MODE_AND  ? all1  :
               m == MODE_OR   ? any1  :
               m == MODE_XOR  ? par   :
               m == MODE_NAND ? ~all1 :
               m == MODE_NOR  ? ~any1 :
               m == MODE_XNOR ? ~par  : 1'b0;
    endfunction
endpackage

// File: rtl/debouncer.sv
// debouncer: 2-flop synchroniser followed by a stable-level counter
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic meta, level;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
        end else begin
            meta  <= raw;
            level <= meta;
            if (level == clean) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                clean <= level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/debounced_gate_unit.sv
// debounced_gate_unit: debounced inputs reduced by a button-selected gate, registered to drive an LED
module debounced_gate_unit
    import gate_unit_pkg::*;
#(
    parameter int N_IN            = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] in_raw,
    input  logic            mode_btn,
    output logic [N_IN-1:0] in_clean,
    output logic [2:0]      mode,
    output logic            mode_changed,
    output logic            out_y
);
    localparam int WW = $clog2(DEBOUNCE_CYCLES + 3);
    logic btn_clean, btn_prev, armed, warm_done, adv;
    logic [WW-1:0] warm;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .rst_n(rst_n), .raw(in_raw[i]), .clean(in_clean[i])
        );
    end

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk(clk), .rst_n(rst_n), .raw(mode_btn), .clean(btn_clean)
    );

    // a button held through reset is debounced high by the end of warm-up, so it stays unarmed until released
    assign warm_done = warm == WW'(DEBOUNCE_CYCLES + 2);
    assign adv       = armed & btn_clean & ~btn_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm         <= '0;
            armed        <= 1'b0;
            btn_prev     <= 1'b0;
            mode         <= MODE_AND;
            mode_changed <= 1'b0;
            out_y        <= 1'b0;
        end else begin
            warm         <= warm_done ? warm : warm + WW'(1);
            armed        <= armed | (warm_done & ~btn_clean);
            btn_prev     <= btn_clean;
            mode         <= mode > MODE_LAST ? MODE_AND :
                            adv ? (mode == MODE_LAST ? MODE_AND : mode + 3'd1) : mode;
            mode_changed <= mode <= MODE_LAST && adv;
            out_y        <= gate_fn(mode, &in_clean, |in_clean, ^in_clean);
        end
    end
endmodule
